timer_responder: RTL and testbench

//  Memory-mapped countdown timer; the responder end of the MEM-stage data-port

---
 rtl/timer_responder_if.sv | 19 +
 rtl/timer_responder.sv | 138 +++++++++++++
 tb/tb_timer_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_responder_if.sv
// ----------------------------------------------------------------------------
// timer_responder_if
//   Data-port bus between the MEM stage (initiator) and a memory-mapped
//   responder such as the countdown timer.
//   addr    : byte address from the initiator
//   byte_en : write byte enables, 4'b0000 means no write
//   wdata   : lane-aligned write data
//   rdata   : read data returned combinationally by the responder
//   Modports: master = initiator side, slave = responder side.
// ----------------------------------------------------------------------------
interface timer_responder_if;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output byte_en, output wdata, input rdata);
    modport slave  (input addr, input byte_en, input wdata, output rdata);
endinterface

// File: rtl/timer_responder.sv
// ----------------------------------------------------------------------------
// timer_responder
//   Memory-mapped countdown timer answering a 16-byte window at BASE.
//   Registers: 0x0 CTRL {IM, MODE[1:0], EN}, 0x4 PRESET, 0x8 COUNT (RO).
//   Offset 0xC and addresses outside the window read as zero.
//   Ports:
//     clk   : system clock, rising-edge state updates
//     reset : asynchronous reset, active-low
//     bus   : data-port slave (addr, byte_en, wdata in; rdata out)
//     irq   : registered interrupt request toward CP0
// ----------------------------------------------------------------------------
module timer_responder #(
    parameter logic [31:0] BASE = 32'h0000_7f00
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_responder_if.slave     bus,
    output logic                 irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;
    logic        pending_next;

    logic [1:0]  offset;
    logic        hit;
    logic        wr_full;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        unused_addr_lsb;

    // Word-aligned accesses only; the byte offset within a word is irrelevant.
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign offset      = bus.addr[3:2];
    assign hit         = (bus.addr[31:4] == BASE[31:4]) && (offset != 2'b11);
    // Sub-word stores are trapped upstream, so only full-word writes count.
    assign wr_full     = hit && (bus.byte_en == 4'b1111);
    assign wr_ctrl     = wr_full && (offset == 2'b00);
    assign wr_preset   = wr_full && (offset == 2'b01);
    // MODE 1x behaves as one-shot; only 01 reloads.
    assign auto_reload = (ctrl[2:1] == 2'b01);

    always_comb begin
        bus.rdata = 32'b0;
        if (hit) begin
            case (offset)
                2'b00:   bus.rdata = {28'b0, ctrl};
                2'b01:   bus.rdata = preset;
                2'b10:   bus.rdata = count;
                default: bus.rdata = 32'b0;
            endcase
        end
    end

    // Pending is sticky in one-shot mode and a single-cycle pulse in
    // auto-reload mode; any accepted CTRL write clears it, even in INT.
    always_comb begin
        pending_next = pending;
        if (state == INT) begin
            pending_next = 1'b1;
        end else if (auto_reload) begin
            pending_next = 1'b0;
        end
        if (wr_ctrl) begin
            pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ctrl    <= 4'b0;
            preset  <= 32'b0;
            count   <= 32'b0;
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            pending <= pending_next;
            irq     <= pending_next & ctrl[3];

            if (wr_preset) begin
                preset <= bus.wdata;
            end

            case (state)
                IDLE: begin
                    if (ctrl[0]) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count == 32'd0) begin
                        // Preset of zero: never decrement below zero.
                        state <= INT;
                    end else begin
                        count <= count - 32'd1;
                        if (count == 32'd1) begin
                            state <= INT;
                        end
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so a CPU write overrides the FSM clearing EN.
            if (wr_ctrl) begin
                ctrl <= bus.wdata[3:0];
            end
        end
    end

endmodule

// File: tb/tb_timer_responder.sv
// ----------------------------------------------------------------------------
// tb_timer_responder
//   Self-checking bench for timer_responder: directed register-access cases
//   plus randomized timer runs compared against a timeline model.
// ----------------------------------------------------------------------------
module tb_timer_responder;

    localparam logic [31:0] CTRL_A   = 32'h0000_7f00;
    localparam logic [31:0] PRESET_A = 32'h0000_7f04;
    localparam logic [31:0] COUNT_A  = 32'h0000_7f08;

    logic clk;
    logic reset;
    logic irq;
    int   n_pass;
    int   n_total;

    timer_responder_if bus ();

    timer_responder #(.BASE(32'h0000_7f00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.addr    = a;
        bus.wdata   = d;
        bus.byte_en = be;
        tick();
        bus.byte_en = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // Timeline model: k = edges since the CTRL write that set EN (k=0 is that
    // edge). Counting starts two edges later; the interrupt edge is reached
    // after max(P,1) further edges; an auto-reload period is that plus two.
    function automatic int first_int(input int p);
        return 2 + ((p == 0) ? 1 : p);
    endfunction

    function automatic int period(input int p);
        return ((p == 0) ? 1 : p) + 2;
    endfunction

    function automatic int sat(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int exp_count(input int k, input int p, input bit auto_m);
        int i0;
        int m;
        i0 = first_int(p);
        if (k < 2) return 0;
        if (!auto_m || k <= i0) return sat(p - (k - 2));
        m = (k - i0 - 1) % period(p);
        if (m == 0) return 0;
        return sat(p - (m - 1));
    endfunction

    function automatic bit exp_irq(input int k, input int p, input bit auto_m, input bit im);
        int i0;
        i0 = first_int(p);
        if (!im || k <= i0) return 1'b0;
        if (!auto_m) return 1'b1;
        return ((k - i0 - 1) % period(p)) == 0;
    endfunction

    function automatic logic [3:0] exp_ctrl(input int k, input int p, input bit auto_m,
                                            input logic [3:0] c);
        if (!auto_m && k > first_int(p)) return c & 4'b1110;
        return c;
    endfunction

    task automatic run_timer(input int p, input logic [1:0] mode, input bit im);
        logic [31:0] d;
        logic [3:0]  c;
        bit          auto_m;
        int          last_k;
        do_reset();
        wr(PRESET_A, p, 4'b1111);
        c = {im, mode, 1'b1};
        auto_m = (mode == 2'b01);
        last_k = auto_m ? first_int(p) + 2 * period(p) + 1 : first_int(p) + 3;
        wr(CTRL_A, {28'b0, c}, 4'b1111);
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) tick();
            rd(COUNT_A, d);
            check($sformatf("count p=%0d m=%0d im=%0d k=%0d", p, mode, im, k),
                  d, exp_count(k, p, auto_m));
            rd(CTRL_A, d);
            check($sformatf("ctrl p=%0d m=%0d im=%0d k=%0d", p, mode, im, k),
                  d, {28'b0, exp_ctrl(k, p, auto_m, c)});
            check($sformatf("irq p=%0d m=%0d im=%0d k=%0d", p, mode, im, k),
                  {31'b0, irq}, {31'b0, exp_irq(k, p, auto_m, im)});
        end
    endtask

    initial begin
        logic [31:0] d;
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b0;
        bus.addr    = 32'b0;
        bus.wdata   = 32'b0;
        bus.byte_en = 4'b0000;
        #12;
        reset = 1'b1;
        tick();

        // Reset state
        rd(CTRL_A, d);   check("rst ctrl", d, 32'h0);
        rd(PRESET_A, d); check("rst preset", d, 32'h0);
        rd(COUNT_A, d);  check("rst count", d, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);

        // Write filtering and decode
        wr(PRESET_A, 32'h0000_0005, 4'b1111);
        wr(PRESET_A, 32'h0000_1234, 4'b0001);
        rd(PRESET_A, d); check("partial write ignored", d, 32'h5);
        wr(COUNT_A, 32'hffff_ffff, 4'b1111);
        rd(COUNT_A, d);  check("count write ignored", d, 32'h0);
        wr(CTRL_A, 32'hffff_fff8, 4'b1111);
        rd(CTRL_A, d);   check("ctrl upper bits", d, 32'h8);
        rd(32'h0000_7f0c, d); check("read 0x7f0c", d, 32'h0);
        rd(32'h0000_7f10, d); check("read 0x7f10", d, 32'h0);
        rd(32'h0000_7f14, d); check("read 0x7f14", d, 32'h0);

        // Spec scenarios, then randomized runs
        run_timer(5, 2'b00, 1'b1);
        run_timer(3, 2'b01, 1'b1);
        run_timer(0, 2'b00, 1'b1);
        run_timer(0, 2'b01, 1'b1);
        for (int r = 0; r < 6; r++) begin
            run_timer($urandom_range(0, 6), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // One-shot irq held until CTRL write, then async reset drops it
        do_reset();
        wr(PRESET_A, 32'd2, 4'b1111);
        wr(CTRL_A, 32'h9, 4'b1111);
        for (int i = 0; i < 8; i++) tick();
        check("oneshot irq held", {31'b0, irq}, 32'h1);
        rd(CTRL_A, d); check("oneshot EN cleared", d, 32'h8);
        wr(CTRL_A, 32'h8, 4'b1111);
        check("ctrl write clears irq", {31'b0, irq}, 32'h0);
        tick();
        check("irq stays clear", {31'b0, irq}, 32'h0);
        wr(CTRL_A, 32'h9, 4'b1111);
        for (int i = 0; i < 5; i++) tick();
        check("irq before reset", {31'b0, irq}, 32'h1);
        reset = 1'b0;
        #1;
        check("reset drops irq async", {31'b0, irq}, 32'h0);
        reset = 1'b1;

        // CPU CTRL write on the INT edge wins over EN clear
        tick();
        do_reset();
        wr(PRESET_A, 32'd1, 4'b1111);
        wr(CTRL_A, 32'h9, 4'b1111);
        for (int i = 0; i < 3; i++) tick();
        wr(CTRL_A, 32'hb, 4'b1111);
        rd(CTRL_A, d); check("simul ctrl wins", d, 32'hb);
        check("simul pending cleared", {31'b0, irq}, 32'h0);
        tick();
        tick();
        rd(COUNT_A, d); check("simul restart load", d, 32'h1);

        // IM=0 run: count expires, irq never rises
        do_reset();
        wr(PRESET_A, 32'd2, 4'b1111);
        wr(CTRL_A, 32'h1, 4'b1111);
        for (int i = 0; i < 8; i++) tick();
        rd(COUNT_A, d); check("im0 count", d, 32'h0);
        rd(CTRL_A, d);  check("im0 ctrl", d, 32'h0);
        check("im0 irq", {31'b0, irq}, 32'h0);

        // Disable mid-count: write lands while COUNT=3, freezes at 2
        do_reset();
        wr(PRESET_A, 32'd6, 4'b1111);
        wr(CTRL_A, 32'h9, 4'b1111);
        for (int i = 0; i < 5; i++) tick();
        rd(COUNT_A, d); check("pre-disable count", d, 32'h3);
        wr(CTRL_A, 32'h8, 4'b1111);
        for (int i = 0; i < 4; i++) tick();
        rd(COUNT_A, d); check("frozen count", d, 32'h2);
        rd(CTRL_A, d);  check("disabled ctrl", d, 32'h8);
        check("disabled irq", {31'b0, irq}, 32'h0);
        wr(PRESET_A, 32'd9, 4'b1111);
        tick();
        rd(COUNT_A, d); check("preset no effect idle", d, 32'h2);

        // Reset mid-count
        do_reset();
        wr(PRESET_A, 32'd7, 4'b1111);
        wr(CTRL_A, 32'h9, 4'b1111);
        for (int i = 0; i < 5; i++) tick();
        rd(COUNT_A, d); check("count before reset", d, 32'h4);
        reset = 1'b0;
        #1;
        check("midreset irq", {31'b0, irq}, 32'h0);
        rd(COUNT_A, d); check("midreset count", d, 32'h0);
        rd(CTRL_A, d);  check("midreset ctrl", d, 32'h0);
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
